// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Bits needed to count 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_divider_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so a borrow shows up in the extra top bit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned   CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, dvd_r, div_r;
  logic [WIDTH-1:0] rem_nxt, q_raw, q_fin, r_fin;
  logic [WIDTH-1:0] dvd_mag, div_mag;
  logic             q_bit, accept;

  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .divisor (div_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // Dividend register doubles as the quotient shift register.
  assign q_raw  = {dvd_r[WIDTH-2:0], q_bit};
  assign accept = in_valid & in_ready;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign div_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_fin   = neg_q ? -q_raw   : q_raw;
  assign r_fin   = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign div_mag = divisor;
  assign q_fin   = q_raw;
  assign r_fin   = rem_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (divisor == '0) ? DONE : BUSY;
      end
      BUSY:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      div_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              dvd_r <= dvd_mag;
              div_r <= div_mag;
              rem_r <= '0;
              cnt   <= '0;
            end
          end
        end
        BUSY: begin
          rem_r <= rem_nxt;
          dvd_r <= q_raw;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, backpressure/reset sequences, random vs model.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: WIDTH=16, 1: WIDTH=8, 2: WIDTH=32
  logic iv [3];
  logic ordy [3];
  logic ir [3];
  logic ov [3];
  logic dz [3];
  logic [15:0] a16, b16, q16, r16;
  logic [7:0]  a8, b8, q8, r8;
  logic [31:0] a32, b32, q32, r32;

  seq_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .dividend(a16), .divisor(b16), .out_valid(ov[0]), .out_ready(ordy[0]),
    .quotient(q16), .remainder(r16), .div_by_zero(dz[0])
  );
  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .dividend(a8), .divisor(b8), .out_valid(ov[1]), .out_ready(ordy[1]),
    .quotient(q8), .remainder(r8), .div_by_zero(dz[1])
  );
  seq_divider #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .dividend(a32), .divisor(b32), .out_valid(ov[2]), .out_ready(ordy[2]),
    .quotient(q32), .remainder(r32), .div_by_zero(dz[2])
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int unsigned wof(input int unsigned i);
    case (i)
      0:       return 16;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain arithmetic on 64-bit values, truncated back to the operand width.
  task automatic model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r, output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
    longint sa, sb;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    if (sb == 0) begin
      q = mask(w); r = a; z = 1'b1;
    end else begin
      q = 64'(sa / sb) & mask(w);
      r = 64'(sa % sb) & mask(w);
      z = 1'b0;
    end
`else
    if (b == 0) begin
      q = mask(w); r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
`endif
  endtask

  task automatic set_in(input int unsigned i, input logic [63:0] a, input logic [63:0] b);
    case (i)
      0:       begin a16 = a[15:0]; b16 = b[15:0]; end
      1:       begin a8  = a[7:0];  b8  = b[7:0];  end
      default: begin a32 = a[31:0]; b32 = b[31:0]; end
    endcase
  endtask

  task automatic rd(input int unsigned i, output logic [63:0] q, output logic [63:0] r);
    case (i)
      0:       begin q = 64'(q16); r = 64'(r16); end
      1:       begin q = 64'(q8);  r = 64'(r8);  end
      default: begin q = 64'(q32); r = 64'(r32); end
    endcase
  endtask

  // Issue one operation with out_ready high, measure edges from accept to out_valid, check results.
  task automatic run_op(input int unsigned i, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input logic ez,
                        input string tag);
    logic [63:0] gq, gr;
    int unsigned lat, n, w;
    w = wof(i);
    @(negedge clk);
    n = 0;
    while (!ir[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir[i]) begin
      fail_now({tag, " in_ready"});
      return;
    end
    set_in(i, a, b);
    iv[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[i] = 1'b0;
    set_in(i, ~a, ~b);
    lat = 0;
    while (!ov[i] && lat < 2 * w + 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!ov[i]) begin
      fail_now({tag, " out_valid"});
      return;
    end
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd0 : 64'(w));
    rd(i, gq, gr);
    check({tag, " quotient"}, gq, eq);
    check({tag, " remainder"}, gr, er);
    check({tag, " div_by_zero"}, 64'(dz[i]), 64'(ez));
`ifndef SEQ_DIVIDER_SIGNED_EN
    if (b != 0) check({tag, " q*d+r"}, (gq * b + gr) & mask(w), a);
`endif
  endtask

  function automatic logic [63:0] rnd(input int unsigned w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 15));
      2:       return mask(w);
      default: return {32'($urandom), 32'($urandom)} & mask(w);
    endcase
  endfunction

  task automatic rand_loop(input int unsigned i, input int unsigned count);
    logic [63:0] a, b, eq, er;
    logic ez;
    int unsigned w;
    w = wof(i);
    for (int unsigned k = 0; k < count; k++) begin
      a = rnd(w);
      b = rnd(w);
      model(w, a, b, eq, er, ez);
      run_op(i, a, b, eq, er, ez, $sformatf("rand w%0d %0h/%0h", w, a, b));
    end
  endtask

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[7];
    logic [63:0] gq, gr;
    int unsigned n;

    tv[0] = '{a: 16'd1000,   b: 16'd7,      q: 16'd142,    r: 16'd6,    z: 1'b0};
    tv[1] = '{a: 16'hFFFF,   b: 16'h0001,   q: 16'hFFFF,   r: 16'h0000, z: 1'b0};
    tv[2] = '{a: 16'd5,      b: 16'd9,      q: 16'd0,      r: 16'd5,    z: 1'b0};
    tv[3] = '{a: 16'd1234,   b: 16'd0,      q: 16'hFFFF,   r: 16'd1234, z: 1'b1};
    tv[4] = '{a: 16'd100,    b: 16'd3,      q: 16'd33,     r: 16'd1,    z: 1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
    tv[5] = '{a: 16'hFFF9,   b: 16'd2,      q: 16'hFFFD,   r: 16'hFFFF, z: 1'b0};
    tv[6] = '{a: 16'h8000,   b: 16'hFFFF,   q: 16'h8000,   r: 16'h0000, z: 1'b0};
`else
    tv[5] = '{a: 16'hFFF9,   b: 16'd2,      q: 16'h7FFC,   r: 16'h0001, z: 1'b0};
    tv[6] = '{a: 16'h8000,   b: 16'hFFFF,   q: 16'h0000,   r: 16'h8000, z: 1'b0};
`endif

    rst = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
      set_in(i, 64'd0, 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      rd(i, gq, gr);
      check($sformatf("reset w%0d out_valid", wof(i)), 64'(ov[i]), 64'd0);
      check($sformatf("reset w%0d in_ready", wof(i)), 64'(ir[i]), 64'd1);
      check($sformatf("reset w%0d div_by_zero", wof(i)), 64'(dz[i]), 64'd0);
      check($sformatf("reset w%0d quotient", wof(i)), gq, 64'd0);
      check($sformatf("reset w%0d remainder", wof(i)), gr, 64'd0);
    end
    rst = 1'b0;

    for (int unsigned k = 0; k < 7; k++)
      run_op(0, 64'(tv[k].a), 64'(tv[k].b), 64'(tv[k].q), 64'(tv[k].r), tv[k].z,
             $sformatf("vec%0d", k));

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    ordy[0] = 1'b0;
    set_in(0, 64'd1000, 64'd7);
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ov[0]) fail_now("bp out_valid");
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp out_valid", 64'(ov[0]), 64'd1);
      check("bp in_ready", 64'(ir[0]), 64'd0);
      check("bp quotient", 64'(q16), 64'd142);
      check("bp remainder", 64'(r16), 64'd6);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release out_valid", 64'(ov[0]), 64'd0);
    check("bp release in_ready", 64'(ir[0]), 64'd1);
    check("bp release quotient kept", 64'(q16), 64'd142);

    // Reset in the middle of a division aborts it.
    @(negedge clk);
    set_in(0, 64'd100, 64'd3);
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst in_ready", 64'(ir[0]), 64'd1);
    check("midrst out_valid", 64'(ov[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk);
      check("midrst idle out_valid", 64'(ov[0]), 64'd0);
      check("midrst idle in_ready", 64'(ir[0]), 64'd1);
    end
    run_op(0, 64'd100, 64'd3, 64'd33, 64'd1, 1'b0, "after rst 100/3");

    fork
      rand_loop(0, 2000);
      rand_loop(1, 2000);
      rand_loop(2, 2000);
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
